pc_fetch_ctrl: RTL and testbench

Fetch-stage controller that sequences the pipeline's PC register. Each cycle it selects the next PC: sequential, ID-stage jump, or EX-stage branch redirect. It drives the PC enable from hazard stalls and a variable-latency instruction-memory handshake, and issues IF/ID and ID/EX flushes. Redirects that arrive while a fetch is outstanding are latched, then applied when the fetch completes; a watchdog flags a hung instruction memory.

---
 rtl/pc_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: next-PC select, PC enable, flushes, deferred redirects, imem watchdog.
// Optional FETCH_PERF_EN builds a saturating fetch-stall cycle counter on stall_cycles_o.
module pc_fetch_ctrl #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int                TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [DATA_W-1:0] br_target_i,
  input  logic              jmp_i,
  input  logic [DATA_W-1:0] jmp_target_i,
  input  logic              imem_ready_i,
  output logic              imem_req_o,
  output logic [DATA_W-1:0] pc_next_o,
  output logic              pc_en_o,
  output logic              fetch_valid_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              fetch_err_o,
  output logic [DATA_W-1:0] stall_cycles_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {BOOT, FETCH, ERR} state_t;

  state_t            state, state_nxt;
  logic              pend_v, pend_v_nxt;
  logic              pend_br, pend_br_nxt;
  logic [DATA_W-1:0] pend_tgt, pend_tgt_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              redir_br, redir_jmp, wd_hit;

  // A stalled ID stage re-presents its jump later, so a jump only counts when not stalled.
  assign redir_br  = br_taken_i;
  assign redir_jmp = jmp_i & ~stall_i & ~br_taken_i;
  assign wd_hit    = (TIMEOUT > 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt     = state;
    pend_v_nxt    = pend_v;
    pend_br_nxt   = pend_br;
    pend_tgt_nxt  = pend_tgt;
    wd_cnt_nxt    = '0;
    imem_req_o    = 1'b0;
    pc_next_o     = pc_i;
    pc_en_o       = 1'b0;
    fetch_valid_o = 1'b0;
    flush_ifid_o  = 1'b0;
    flush_idex_o  = 1'b0;
    fetch_err_o   = 1'b0;
    case (state)
      BOOT: begin
        pc_next_o = RESET_VECTOR;
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req_o   = 1'b1;
        flush_ifid_o = redir_br | redir_jmp;
        flush_idex_o = redir_br;
        if (imem_ready_i) begin
          if (redir_br || redir_jmp || pend_v) begin
            pc_en_o    = 1'b1;
            pend_v_nxt = 1'b0;
            if (redir_br)    pc_next_o = br_target_i;
            else if (pend_v) pc_next_o = pend_tgt;
            else             pc_next_o = jmp_target_i;
          end else if (!stall_i) begin
            pc_next_o     = pc_i + DATA_W'(4);
            pc_en_o       = 1'b1;
            fetch_valid_o = 1'b1;
          end
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
          // A pending branch is older than any jump behind it, so jumps never displace it.
          if (redir_br) begin
            pend_v_nxt   = 1'b1;
            pend_br_nxt  = 1'b1;
            pend_tgt_nxt = br_target_i;
          end else if (redir_jmp && !(pend_v && pend_br)) begin
            pend_v_nxt   = 1'b1;
            pend_br_nxt  = 1'b0;
            pend_tgt_nxt = jmp_target_i;
          end
          if (wd_hit) state_nxt = ERR;
        end
      end
      ERR: begin
        fetch_err_o = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Control state register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pend_v  <= 1'b0;
      pend_br <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      pend_v  <= pend_v_nxt;
      pend_br <= pend_br_nxt;
      wd_cnt  <= wd_cnt_nxt;
    end
  end

  // Pending target is qualified by pend_v and needs no reset
  always_ff @(posedge clk) begin
    pend_tgt <= pend_tgt_nxt;
  end

`ifdef FETCH_PERF_EN
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + DATA_W'(1);
  endfunction

  logic [DATA_W-1:0] stall_cnt;

  // Performance counter boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_cnt <= '0;
    else if (state == FETCH && !pc_en_o) stall_cnt <= sat_inc(stall_cnt);
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: vector table with a tracking PC register, plus
// hand-written watchdog and asynchronous-reset sequences.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_reg;
  logic        stall_i = 1'b0, br_taken_i = 1'b0, jmp_i = 1'b0, imem_ready_i = 1'b0;
  logic [31:0] br_target_i = '0, jmp_target_i = '0;
  logic        imem_req_o, pc_en_o, fetch_valid_o, flush_ifid_o, flush_idex_o, fetch_err_o;
  logic [31:0] pc_next_o, stall_cycles_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_reg), .stall_i(stall_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .jmp_i(jmp_i), .jmp_target_i(jmp_target_i), .imem_ready_i(imem_ready_i),
    .imem_req_o(imem_req_o), .pc_next_o(pc_next_o), .pc_en_o(pc_en_o),
    .fetch_valid_o(fetch_valid_o), .flush_ifid_o(flush_ifid_o),
    .flush_idex_o(flush_idex_o), .fetch_err_o(fetch_err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  // PC register fed by the DUT, as in the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc_reg <= RV;
    else if (pc_en_o) pc_reg <= pc_next_o;
  end

  typedef struct {
    logic        rdy, stall, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        en, val, fi, fe;
    logic [31:0] nxt;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic rdy, input logic stall, input logic br,
                      input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                      input logic en, input logic val, input logic fi, input logic fe,
                      input logic [31:0] nxt);
    tv[i] = '{rdy, stall, br, bt, jmp, jt, en, val, fi, fe, nxt};
  endtask

  task automatic drive(input logic rdy, input logic stall, input logic br,
                       input logic [31:0] bt, input logic jmp, input logic [31:0] jt);
    imem_ready_i = rdy; stall_i = stall; br_taken_i = br;
    br_target_i = bt; jmp_i = jmp; jmp_target_i = jt;
  endtask

  initial begin
    int sc_exp;
    //        i  rdy st br bt            jmp jt          en val fi fe nxt
    setv( 0, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'hBFC0_0004);
    setv( 1, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'hBFC0_0008);
    setv( 2, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'hBFC0_000C);
    setv( 3, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'hBFC0_0010);
    setv( 4, 1, 1, 0, 0,            0, 0,            0, 0, 0, 0, 0);
    setv( 5, 1, 1, 0, 0,            0, 0,            0, 0, 0, 0, 0);
    setv( 6, 1, 1, 0, 0,            0, 0,            0, 0, 0, 0, 0);
    setv( 7, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'hBFC0_0014);
    setv( 8, 1, 0, 1, 32'h100,      1, 32'h200,      1, 0, 1, 1, 32'h100);
    setv( 9, 1, 1, 0, 0,            1, 32'h500,      0, 0, 0, 0, 0);
    setv(10, 1, 1, 1, 32'h600,      0, 0,            1, 0, 1, 1, 32'h600);
    setv(11, 0, 0, 0, 0,            1, 32'h200,      0, 0, 1, 0, 0);
    setv(12, 0, 0, 1, 32'h300,      0, 0,            0, 0, 1, 1, 0);
    setv(13, 0, 0, 0, 0,            1, 32'h700,      0, 0, 1, 0, 0);
    setv(14, 0, 0, 0, 0,            0, 0,            0, 0, 0, 0, 0);
    setv(15, 1, 0, 0, 0,            0, 0,            1, 0, 0, 0, 32'h300);
    setv(16, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'h304);
    setv(17, 0, 0, 0, 0,            1, 32'h800,      0, 0, 1, 0, 0);
    setv(18, 0, 0, 0, 0,            1, 32'h900,      0, 0, 1, 0, 0);
    setv(19, 1, 1, 0, 0,            0, 0,            1, 0, 0, 0, 32'h900);
    setv(20, 1, 0, 1, 32'hFFFF_FFFC, 0, 0,           1, 0, 1, 1, 32'hFFFF_FFFC);
    setv(21, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'h0000_0000);
    setv(22, 1, 0, 0, 0,            0, 0,            1, 1, 0, 0, 32'h0000_0004);

    // Reset values
    #12;
    chk("rst pc_next", pc_next_o, RV);
    chk("rst req", 32'(imem_req_o), 0);
    chk("rst en", 32'(pc_en_o), 0);
    chk("rst valid", 32'(fetch_valid_o), 0);
    chk("rst flush_ifid", 32'(flush_ifid_o), 0);
    chk("rst flush_idex", 32'(flush_idex_o), 0);
    chk("rst err", 32'(fetch_err_o), 0);
    chk("rst stall_cycles", stall_cycles_o, 0);

    // BOOT cycle
    @(negedge clk); rst_n = 1'b1; drive(1, 0, 0, 0, 0, 0); #1;
    chk("boot req", 32'(imem_req_o), 0);
    chk("boot en", 32'(pc_en_o), 0);
    chk("boot pc_next", pc_next_o, RV);

    sc_exp = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tv[i].rdy, tv[i].stall, tv[i].br, tv[i].bt, tv[i].jmp, tv[i].jt);
      #1;
      chk($sformatf("v%0d req", i), 32'(imem_req_o), 1);
      chk($sformatf("v%0d en", i), 32'(pc_en_o), 32'(tv[i].en));
      chk($sformatf("v%0d valid", i), 32'(fetch_valid_o), 32'(tv[i].val));
      chk($sformatf("v%0d flush_ifid", i), 32'(flush_ifid_o), 32'(tv[i].fi));
      chk($sformatf("v%0d flush_idex", i), 32'(flush_idex_o), 32'(tv[i].fe));
      if (tv[i].en) chk($sformatf("v%0d pc_next", i), pc_next_o, tv[i].nxt);
`ifdef FETCH_PERF_EN
      chk($sformatf("v%0d stall_cycles", i), stall_cycles_o, 32'(sc_exp));
`else
      chk($sformatf("v%0d stall_cycles", i), stall_cycles_o, 0);
`endif
      if (!tv[i].en) sc_exp++;
    end

    // Watchdog: 64 consecutive not-ready cycles
    @(negedge clk); rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk); #1;
      if (k == 64) begin
        chk("wd pre err", 32'(fetch_err_o), 0);
        chk("wd pre req", 32'(imem_req_o), 1);
      end
    end
    @(negedge clk); #1;
    chk("wd err", 32'(fetch_err_o), 1);
    chk("wd req", 32'(imem_req_o), 0);
    chk("wd en", 32'(pc_en_o), 0);
    imem_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("wd err sticky", 32'(fetch_err_o), 1);
    chk("wd req sticky", 32'(imem_req_o), 0);
    rst_n = 1'b0; #1;
    chk("wd err cleared", 32'(fetch_err_o), 0);

    // Asynchronous reset with a branch pending
    @(negedge clk); rst_n = 1'b1; drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 1, 32'h300, 0, 0); #1;
    chk("pend br flush_idex", 32'(flush_idex_o), 1);
    chk("pend br en", 32'(pc_en_o), 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); #2;
    rst_n = 1'b0; #1;
    chk("arst pc_next", pc_next_o, RV);
    chk("arst req", 32'(imem_req_o), 0);
    chk("arst en", 32'(pc_en_o), 0);
    chk("arst flush_ifid", 32'(flush_ifid_o), 0);
    chk("arst flush_idex", 32'(flush_idex_o), 0);
    @(negedge clk); rst_n = 1'b1; drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("post arst pc_i", pc_reg, RV);
    chk("post arst pc_next", pc_next_o, 32'hBFC0_0004);
    chk("post arst valid", 32'(fetch_valid_o), 1);
    chk("post arst en", 32'(pc_en_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
